reorder_buffer: RTL

- Circular in-order retirement queue between issue and the register file's commit port.
- Allocates one entry per issued instruction and returns that entry's rob_id, which the register file records as the rename dep.
- Captures results from the common data bus; commits at most one entry per cycle in program order, driving the register file's set_value_* inputs.
- On a committed branch mispredict, flushes itself and pulses clear plus a redirect PC to the rest of the core.

---
 rtl/reorder_buffer_pkg.sv | 36 +++
 rtl/reorder_buffer_if.sv | 60 ++++++
 rtl/reorder_buffer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the in-order reorder buffer.
// Index width, depth and entry type encodings live here for all ROB users.
package reorder_buffer_pkg;

  localparam int ROB_INDEX_BIT = 3;
  localparam int ROB_SIZE      = 2 ** ROB_INDEX_BIT;

  typedef logic [ROB_INDEX_BIT-1:0] rob_id_t;
  typedef logic [ROB_INDEX_BIT:0]   rob_cnt_t;

  localparam rob_cnt_t ROB_SIZE_CNT = rob_cnt_t'(ROB_SIZE);

  typedef enum logic [1:0] {
    ROB_T_REG    = 2'd0,
    ROB_T_STORE  = 2'd1,
    ROB_T_BRANCH = 2'd2
  } rob_type_e;

  typedef struct packed {
    logic        busy;
    logic        ready;
    rob_type_e   typ;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [31:0] pc;
    logic        pred_taken;
    logic        taken;
    logic [31:0] target;
  } rob_entry_t;

  // Restart address after a mispredicted branch retires.
  function automatic logic [31:0] rob_redirect(input rob_entry_t e);
    return e.taken ? e.target : e.pc + 32'd4;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / CDB / query / commit signal bundle around the reorder buffer.
// ROB_DBG_COMMIT_EN adds the commit trace signals dbg_commit and dbg_commit_addr.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic        issue_valid;
  rob_type_e   issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc;
  logic        issue_pred_taken;
  logic        full;
  rob_id_t     tail_id;

  logic        wb_valid;
  rob_id_t     wb_rob_id;
  logic [31:0] wb_value;
  logic        wb_taken;
  logic [31:0] wb_target;

  rob_id_t     qry_id1;
  rob_id_t     qry_id2;
  logic        qry_ready1;
  logic        qry_ready2;
  logic [31:0] qry_val1;
  logic [31:0] qry_val2;

  logic [4:0]  set_value_id;
  logic [31:0] set_value;
  rob_id_t     set_value_rob_id;
  logic        store_commit;
  logic        clear;
  logic [31:0] redirect_pc;
`ifdef ROB_DBG_COMMIT_EN
  logic        dbg_commit;
  logic [31:0] dbg_commit_addr;
`endif

  modport master (
    output issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
    output wb_valid, wb_rob_id, wb_value, wb_taken, wb_target,
    output qry_id1, qry_id2,
    input  full, tail_id, qry_ready1, qry_ready2, qry_val1, qry_val2,
    input  set_value_id, set_value, set_value_rob_id, store_commit, clear, redirect_pc
`ifdef ROB_DBG_COMMIT_EN
    , input dbg_commit, dbg_commit_addr
`endif
  );

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
    input  wb_valid, wb_rob_id, wb_value, wb_taken, wb_target,
    input  qry_id1, qry_id2,
    output full, tail_id, qry_ready1, qry_ready2, qry_val1, qry_val2,
    output set_value_id, set_value, set_value_rob_id, store_commit, clear, redirect_pc
`ifdef ROB_DBG_COMMIT_EN
    , output dbg_commit, dbg_commit_addr
`endif
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocate at tail, capture CDB results, retire from head.
// ROB_DBG_COMMIT_EN enables a one-cycle commit trace (dbg_commit / dbg_commit_addr).
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  reorder_buffer_if.slave bus
);

  rob_entry_t  rob_q [ROB_SIZE];
  rob_entry_t  rob_d [ROB_SIZE];
  rob_id_t     head_q, head_d;
  rob_id_t     tail_q, tail_d;
  rob_cnt_t    count_q, count_d;

  logic [4:0]  set_value_id_q, set_value_id_d;
  logic [31:0] set_value_q, set_value_d;
  rob_id_t     set_value_rob_id_q, set_value_rob_id_d;
  logic        store_commit_q, store_commit_d;
  logic        clear_q, clear_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
`ifdef ROB_DBG_COMMIT_EN
  logic        dbg_commit_q, dbg_commit_d;
  logic [31:0] dbg_commit_addr_q, dbg_commit_addr_d;
`endif

  rob_entry_t  head_e;
  logic        full;
  logic        do_alloc;
  logic        do_commit;
  logic        mispredict;

  assign full       = (count_q == ROB_SIZE_CNT);
  assign head_e     = rob_q[head_q];
  assign do_commit  = head_e.busy && head_e.ready;
  assign mispredict = do_commit && (head_e.typ == ROB_T_BRANCH) &&
                      (head_e.taken != head_e.pred_taken);
  assign do_alloc   = bus.issue_valid && !full && !clear_q;

  always_comb begin
    rob_d              = rob_q;
    head_d             = head_q;
    tail_d             = tail_q;
    count_d            = count_q;
    set_value_id_d     = 5'd0;
    set_value_d        = set_value_q;
    set_value_rob_id_d = set_value_rob_id_q;
    store_commit_d     = 1'b0;
    clear_d            = 1'b0;
    redirect_pc_d      = redirect_pc_q;
`ifdef ROB_DBG_COMMIT_EN
    dbg_commit_d       = 1'b0;
    dbg_commit_addr_d  = dbg_commit_addr_q;
`endif

    if (bus.wb_valid && rob_q[bus.wb_rob_id].busy) begin
      rob_d[bus.wb_rob_id].ready  = 1'b1;
      rob_d[bus.wb_rob_id].value  = bus.wb_value;
      rob_d[bus.wb_rob_id].taken  = bus.wb_taken;
      rob_d[bus.wb_rob_id].target = bus.wb_target;
    end

    if (do_commit) begin
      rob_d[head_q].busy  = 1'b0;
      rob_d[head_q].ready = 1'b0;
      head_d              = head_q + rob_id_t'(1);
      if (head_e.typ == ROB_T_REG || (head_e.typ == ROB_T_BRANCH && head_e.rd != 5'd0)) begin
        set_value_id_d     = head_e.rd;
        set_value_d        = head_e.value;
        set_value_rob_id_d = head_q;
      end
      if (head_e.typ == ROB_T_STORE) store_commit_d = 1'b1;
`ifdef ROB_DBG_COMMIT_EN
      dbg_commit_d      = 1'b1;
      dbg_commit_addr_d = head_e.pc;
`endif
    end

    // Allocation is applied after retirement so it owns the tail slot.
    if (do_alloc) begin
      rob_d[tail_q] = '{busy: 1'b1, ready: 1'b0, typ: bus.issue_type, rd: bus.issue_rd,
                        value: 32'd0, pc: bus.issue_pc, pred_taken: bus.issue_pred_taken,
                        taken: 1'b0, target: 32'd0};
      tail_d = tail_q + rob_id_t'(1);
    end

    count_d = count_q + rob_cnt_t'(do_alloc) - rob_cnt_t'(do_commit);

    if (mispredict) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        rob_d[i].busy  = 1'b0;
        rob_d[i].ready = 1'b0;
      end
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      clear_d       = 1'b1;
      redirect_pc_d = rob_redirect(head_e);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rob_q              <= '{default: '0};
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      set_value_id_q     <= '0;
      set_value_q        <= '0;
      set_value_rob_id_q <= '0;
      store_commit_q     <= 1'b0;
      clear_q            <= 1'b0;
      redirect_pc_q      <= '0;
`ifdef ROB_DBG_COMMIT_EN
      dbg_commit_q       <= 1'b0;
      dbg_commit_addr_q  <= '0;
`endif
    end else if (rdy_in) begin
      rob_q              <= rob_d;
      head_q             <= head_d;
      tail_q             <= tail_d;
      count_q            <= count_d;
      set_value_id_q     <= set_value_id_d;
      set_value_q        <= set_value_d;
      set_value_rob_id_q <= set_value_rob_id_d;
      store_commit_q     <= store_commit_d;
      clear_q            <= clear_d;
      redirect_pc_q      <= redirect_pc_d;
`ifdef ROB_DBG_COMMIT_EN
      dbg_commit_q       <= dbg_commit_d;
      dbg_commit_addr_q  <= dbg_commit_addr_d;
`endif
    end
  end

  assign bus.full             = full;
  assign bus.tail_id          = tail_q;
  assign bus.qry_ready1       = rob_q[bus.qry_id1].busy && rob_q[bus.qry_id1].ready;
  assign bus.qry_ready2       = rob_q[bus.qry_id2].busy && rob_q[bus.qry_id2].ready;
  assign bus.qry_val1         = rob_q[bus.qry_id1].value;
  assign bus.qry_val2         = rob_q[bus.qry_id2].value;
  assign bus.set_value_id     = set_value_id_q;
  assign bus.set_value        = set_value_q;
  assign bus.set_value_rob_id = set_value_rob_id_q;
  assign bus.store_commit     = store_commit_q;
  assign bus.clear            = clear_q;
  assign bus.redirect_pc      = redirect_pc_q;
`ifdef ROB_DBG_COMMIT_EN
  assign bus.dbg_commit       = dbg_commit_q;
  assign bus.dbg_commit_addr  = dbg_commit_addr_q;
`endif

endmodule
